// File: rtl/seq_pkg.sv
// Shared types and constants for the serial pattern transmitter.
package seq_pkg;

  // FSM state encodings.
  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_SEND = 2'b01,
    ST_GAP  = 2'b10,
    ST_FIN  = 2'b11
  } seq_state_e;

  // Default detector pattern.
  localparam logic [3:0] SEQ_1011 = 4'b1011;

  // Reload value of the gap down-counter. With no gap the GAP state is
  // unreachable, so zero is returned rather than a negative count.
  function automatic logic [3:0] gap_last(input int gap);
    return (gap > 0) ? 4'(gap - 1) : 4'd0;
  endfunction

endpackage

// File: rtl/seq_shift_reg.sv
// W-bit parallel-load shift register, MSB out, serial fill at the LSB.
// The transmitter feeds msb back into ser_in so the register rotates and
// the same pattern can be replayed for every repetition.
module seq_shift_reg #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic         shift,
  input  logic [W-1:0] d_in,
  input  logic         ser_in,
  output logic         msb
);

  logic [W-1:0] sr_q, sr_d;

  // Load has priority over shift; otherwise hold.
  always_comb begin
    sr_d = sr_q;
    if (load)       sr_d = d_in;
    else if (shift) sr_d = {sr_q[W-2:0], ser_in};
  end

  // Register with async clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sr_q <= '0;
    else        sr_q <= sr_d;
  end

  assign msb = sr_q[W-1];

endmodule

// File: rtl/seq_pattern_tx.sv
// Serial pattern transmitter: sends a captured W-bit pattern MSB-first,
// rep_count times, with an optional idle gap between copies.
// All outputs come straight from flops; the values loaded on each edge are
// what the state being entered presents for the following cycle.
module seq_pattern_tx
  import seq_pkg::*;
#(
  parameter int W          = 4,
  parameter int GAP_CYCLES = 0,
  parameter int CW         = 8
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          start,
  input  logic [W-1:0]  pattern_in,
  input  logic [CW-1:0] rep_count,
  output logic          dout,
  output logic          dout_valid,
  output logic          busy,
  output logic          done
);

  localparam int             BW       = $clog2(W);
  localparam logic [BW-1:0]  BIT_MSB  = BW'(W - 1);
  localparam logic [3:0]     GAP_LAST = gap_last(GAP_CYCLES);

  seq_state_e     state_q, state_d;
  logic [BW-1:0]  bit_cnt_q, bit_cnt_d;   // index of the bit currently on dout
  logic [CW-1:0]  rep_cnt_q, rep_cnt_d;   // copies remaining, including the current one
  logic [3:0]     gap_cnt_q, gap_cnt_d;   // gap cycles remaining after this one
  logic           dout_q, dout_d;
  logic           dout_valid_q, dout_valid_d;
  logic           busy_q, busy_d;
  logic           done_q, done_d;

  logic           sr_load, sr_shift, sr_msb, emit;

  // The register always holds the pattern rotated so its MSB is the next bit
  // to send; the first bit bypasses it straight from pattern_in.
  seq_shift_reg #(.W(W)) u_shift (
    .clk    (clk),
    .rst_n  (reset_n),
    .load   (sr_load),
    .shift  (sr_shift),
    .d_in   ({pattern_in[W-2:0], pattern_in[W-1]}),
    .ser_in (sr_msb),
    .msb    (sr_msb)
  );

  // Next-state, counter and registered-output logic.
  always_comb begin
    state_d      = state_q;
    bit_cnt_d    = bit_cnt_q;
    rep_cnt_d    = rep_cnt_q;
    gap_cnt_d    = gap_cnt_q;
    dout_d       = 1'b0;
    dout_valid_d = 1'b0;
    busy_d       = 1'b0;
    done_d       = 1'b0;
    sr_load      = 1'b0;
    sr_shift     = 1'b0;
    emit         = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (rep_count != '0) begin
            state_d      = ST_SEND;
            sr_load      = 1'b1;
            rep_cnt_d    = rep_count;
            bit_cnt_d    = BIT_MSB;
            dout_d       = pattern_in[W-1];
            dout_valid_d = 1'b1;
            busy_d       = 1'b1;
          end else begin
            state_d = ST_FIN;
            done_d  = 1'b1;
          end
        end
      end
      ST_SEND: begin
        if (bit_cnt_q != '0) begin
          bit_cnt_d = bit_cnt_q - BW'(1);
          emit      = 1'b1;
        end else if (rep_cnt_q == CW'(1)) begin
          rep_cnt_d = '0;
          state_d   = ST_FIN;
          done_d    = 1'b1;
        end else begin
          rep_cnt_d = rep_cnt_q - CW'(1);
          if (GAP_CYCLES > 0) begin
            state_d   = ST_GAP;
            gap_cnt_d = GAP_LAST;
            busy_d    = 1'b1;
          end else begin
            bit_cnt_d = BIT_MSB;
            emit      = 1'b1;
          end
        end
      end
      ST_GAP: begin
        if (gap_cnt_q != '0) begin
          gap_cnt_d = gap_cnt_q - 4'd1;
          busy_d    = 1'b1;
        end else begin
          state_d   = ST_SEND;
          bit_cnt_d = BIT_MSB;
          emit      = 1'b1;
        end
      end
      ST_FIN:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    if (emit) begin
      dout_d       = sr_msb;
      dout_valid_d = 1'b1;
      busy_d       = 1'b1;
      sr_shift     = 1'b1;
    end
  end

  // State, counters and outputs; async clear drops outputs immediately.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_IDLE;
      bit_cnt_q    <= '0;
      rep_cnt_q    <= '0;
      gap_cnt_q    <= '0;
      dout_q       <= 1'b0;
      dout_valid_q <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      bit_cnt_q    <= bit_cnt_d;
      rep_cnt_q    <= rep_cnt_d;
      gap_cnt_q    <= gap_cnt_d;
      dout_q       <= dout_d;
      dout_valid_q <= dout_valid_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
    end
  end

  assign dout       = dout_q;
  assign dout_valid = dout_valid_q;
  assign busy       = busy_q;
  assign done       = done_q;

endmodule
